// File: rtl/connect_fork_rr_if.sv
// Handshake bundle for connect_fork_rr: one valid/ready input stream and
// CONNECT_NUM parallel valid/ready output channels.
//   master : the surroundings (producer drives RECEIVE_*, consumers drive SEND_READY)
//   slave  : the fork itself
interface connect_fork_rr_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3
);

  logic                              RECEIVE_VALID;
  logic [DATA_WIDTH-1:0]             RECEIVE_DATA;
  logic                              RECEIVE_READY;
  logic [CONNECT_NUM-1:0]            SEND_VALID;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA;
  logic [CONNECT_NUM-1:0]            SEND_READY;

  modport master (
    output RECEIVE_VALID,
    output RECEIVE_DATA,
    output SEND_READY,
    input  RECEIVE_READY,
    input  SEND_VALID,
    input  SEND_DATA
  );

  modport slave (
    input  RECEIVE_VALID,
    input  RECEIVE_DATA,
    input  SEND_READY,
    output RECEIVE_READY,
    output SEND_VALID,
    output SEND_DATA
  );

endinterface

// File: rtl/connect_fork_rr.sv
// Registered fork: a one-entry holding register feeding CONNECT_NUM channels.
// MODE=0 hands each item to a single ready channel chosen round-robin;
// MODE=1 broadcasts each item, tracking per-channel completion in done_q so
// that channels may take the item in any order and never see it twice.
module connect_fork_rr #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int MODE        = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  connect_fork_rr_if.slave bus,
  output logic             BUSY
);

  localparam int PTR_W = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CONNECT_NUM - 1);

  logic                   buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0]  buf_data_q, buf_data_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CONNECT_NUM-1:0] done_q, done_d;

  logic [PTR_W-1:0]       grant;
  logic                   grant_found;
  int                     scan_idx;
  logic [CONNECT_NUM-1:0] send_valid;
  logic [CONNECT_NUM-1:0] chan_hs;
  logic                   item_done;
  logic                   recv_ready;
  logic                   recv_hs;

  // Round-robin search: first ready channel at or after rr_ptr, wrapping.
  always_comb begin
    grant       = rr_ptr_q;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < CONNECT_NUM; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= CONNECT_NUM) begin
        scan_idx = scan_idx - CONNECT_NUM;
      end
      if (!grant_found && bus.SEND_READY[scan_idx]) begin
        grant       = PTR_W'(scan_idx);
        grant_found = 1'b1;
      end
    end
  end

  // Per-mode channel valids, completion of the held item, and pointer/done update.
  always_comb begin
    send_valid = '0;
    chan_hs    = '0;
    item_done  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    done_d     = done_q;
    if (MODE == 0) begin
      // Valid follows ready here on purpose: only the granted channel sees the item.
      if (buf_valid_q && grant_found) begin
        send_valid[grant] = 1'b1;
      end
      item_done = buf_valid_q & grant_found;
      if (item_done) begin
        rr_ptr_d = (grant == PTR_LAST) ? '0 : grant + 1'b1;
      end
      done_d = '0;
    end else begin
      // Valid stays up per channel until that channel has taken the item.
      send_valid = {CONNECT_NUM{buf_valid_q}} & ~done_q;
      chan_hs    = send_valid & bus.SEND_READY;
      item_done  = buf_valid_q & (&(done_q | chan_hs));
      done_d     = item_done ? '0 : (done_q | chan_hs);
      rr_ptr_d   = '0;
    end
  end

  assign recv_ready = !buf_valid_q | item_done;
  assign recv_hs    = bus.RECEIVE_VALID & recv_ready;

  // Holding register: load on input handshake, empty on completion without refill.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (recv_hs) begin
      buf_valid_d = 1'b1;
      buf_data_d  = bus.RECEIVE_DATA;
    end else if (item_done) begin
      buf_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held item and clears fairness/broadcast tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      rr_ptr_q    <= '0;
      done_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      rr_ptr_q    <= rr_ptr_d;
      done_q      <= done_d;
    end
  end

  assign bus.RECEIVE_READY = recv_ready;
  assign bus.SEND_VALID    = send_valid;
  assign bus.SEND_DATA     = {CONNECT_NUM{buf_data_q}};
  assign BUSY              = buf_valid_q;

endmodule

// File: doc/connect_fork_rr.md
Name: connect_fork_rr

Overview:
- Registered, parametrised successor to the combinational fork.
- Takes one valid/ready input stream and distributes each item to CONNECT_NUM output channels.
- Two modes: unicast with round-robin fairness across ready channels, or broadcast where every channel receives every item exactly once.
- Sits between a token producer and a bank of parallel consumers (e.g. function units). One-entry holding register gives a registered data path at full throughput.

Parameters:
DATA_WIDTH, 32, width of one data item
CONNECT_NUM, 3, number of output channels (>=1)
MODE, 0, 0 = unicast round-robin, 1 = broadcast

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
RECEIVE_VALID  input  1  input item valid
RECEIVE_DATA  input  DATA_WIDTH  input item
RECEIVE_READY  output  1  block accepts input this cycle
SEND_VALID  output  CONNECT_NUM  per-channel valid
SEND_DATA  output  DATA_WIDTH*CONNECT_NUM  per-channel data; channel i at bits [W*(i+1)-1 : W*i]
SEND_READY  input  CONNECT_NUM  per-channel ready
BUSY  output  1  holding register occupied

Behaviour:
- Reset (RST_N low, asynchronous): buf_valid=0, buf_data=0, rr_ptr=0, done=0.
  - Outputs therefore: SEND_VALID=0, SEND_DATA=0, BUSY=0, RECEIVE_READY=1.
  - Asserting reset mid-operation discards any held item. No output handshake may complete while RST_N is low.
- State: buf_valid, buf_data[W], rr_ptr[clog2(N)] (unicast), done[N] (broadcast). BUSY = buf_valid.
- Every channel's SEND_DATA is driven from buf_data.
- Input handshake: RECEIVE_VALID & RECEIVE_READY.
  - RECEIVE_READY = !buf_valid | release, where release means the held item completes this cycle.
  - On input handshake: buf_data <= RECEIVE_DATA, buf_valid <= 1.
  - On release with no new input: buf_valid <= 0.
- Latency: an item accepted at edge k appears on SEND_* in cycle k+1. Sustained throughput is 1 item/cycle whenever a completing output is available.
- Unicast (MODE=0):
  - grant = first i with SEND_READY[i]=1, searching from rr_ptr upward and wrapping at CONNECT_NUM-1 -> 0.
  - SEND_VALID[grant] = buf_valid; all other SEND_VALID bits = 0. With no ready channel, SEND_VALID = 0. Valid depends combinationally on ready, matching the existing fork contract.
  - release = buf_valid & |SEND_READY.
  - On release: rr_ptr <= (grant+1) mod CONNECT_NUM. rr_ptr is unchanged when nothing transfers.
  - CONNECT_NUM=1: rr_ptr is constant 0 and the block is a plain 1-entry pipeline register.
- Broadcast (MODE=1):
  - SEND_VALID[i] = buf_valid & !done[i]. This is independent of SEND_READY, and valid never drops until that channel takes the item.
  - Channel handshake h[i] = SEND_VALID[i] & SEND_READY[i].
  - release = buf_valid & &(done | h).
  - On release: done <= 0. Otherwise: done <= done | h.
  - Channels may accept in any order and in different cycles. No channel ever sees the same item twice.
  - New input loads only in a release cycle or when empty, so done is always 0 when a new item becomes visible.
- Simultaneous events: input handshake and release in the same cycle replaces the item with no bubble, and done clears.
- Data stability: buf_data is constant while buf_valid=1 and release=0.

Test Plan:
- Reset: hold RST_N=0 with RECEIVE_VALID=1 and data 0xA5 -> SEND_VALID=0, BUSY=0, RECEIVE_READY=1. Release reset, next edge -> SEND_VALID nonzero with data 0xA5 one cycle later.
- Unicast fairness: N=3, SEND_READY=3'b111 constantly, stream 0..5 -> items go to channels 0,1,2,0,1,2, one per cycle with no bubbles.
- Unicast skip: SEND_READY=3'b100 with rr_ptr=0, item 0x11 -> delivered on channel 2 and rr_ptr becomes 0. Then SEND_READY=3'b000 -> SEND_VALID=0, RECEIVE_READY=0, item held and stable.
- Broadcast staggered: N=3, item 0x42. Ready ch0 in cycle 1, ch2 in cycle 2, ch1 in cycle 4 -> each channel handshakes once. RECEIVE_READY=1 only in cycle 4, next item visible in cycle 5 with done=0.
- Broadcast full rate: all SEND_READY=1, stream 10 items -> each channel receives all 10 in order, 1 item/cycle.
- Mid-operation reset: broadcast with done=3'b011, assert RST_N=0 asynchronously -> SEND_VALID=0 immediately. After reset, the next item goes to all 3 channels.
